systolic_mm_engine: RTL and testbench
=====================================

SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

Interface
REQ-001 SHALL have parameter N, default 4, meaning array dimension (N x N PEs, N >= 1).
REQ-002 SHALL have parameter DW, default 8, meaning operand width.
REQ-003 SHALL have parameter AW, default 2*DW+$clog2(N)+1, meaning accumulator and result width.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  job request, sampled in IDLE only.
REQ-007 SHALL have port signed_mode  input  1  1 = two's-complement operands, sampled with start.
REQ-008 SHALL have port acc_mode  input  1  1 = keep previous accumulators (C += A*B), sampled with start.
REQ-009 SHALL have port in_valid  input  1  operand pair valid.
REQ-010 SHALL have port in_ready  output  1  engine accepts operand pair.
REQ-011 SHALL have port a_data  input  DW  A element, row-major order.
REQ-012 SHALL have port b_data  input  DW  B element, column-major order.
REQ-013 SHALL have port out_valid  output  1  result element valid.
REQ-014 SHALL have port out_ready  input  1  sink accepts result.
REQ-015 SHALL have port out_data  output  AW  C element, row-major order.
REQ-016 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-017 SHALL have port done  output  1  one-cycle pulse at job end.

Function
REQ-018 SHALL implement FSM IDLE -> LOAD -> FEED -> OUT -> IDLE, registered state.
REQ-019 SHALL leave IDLE on start=1, latching signed_mode/acc_mode; entering LOAD the next cycle.
REQ-020 SHALL in LOAD drive in_ready=1 and store a pair on each in_valid&in_ready; index counter 0..N*N-1; element k of A = A[k/N][k%N], of B = B[k%N][k/N].
REQ-021 SHALL transition LOAD -> FEED on the cycle after the N*N-th accepted pair; in_ready=0 outside LOAD; in_valid ignored outside LOAD.
REQ-022 SHALL in FEED run feed counter t = 0..3N-3 (3N-2 cycles); row-i A input = A[i][t-i] and column-j B input = B[t-j][j] when 0 <= t-i,t-j < N, else 0 (skewed injection).
REQ-023 SHALL have each PE per FEED cycle: acc += a*b; forward a right, b down with one-cycle register delay.
REQ-024 SHALL clear all accumulators on the first FEED cycle when latched acc_mode=0; retain them when acc_mode=1.
REQ-025 SHALL form products at 2*DW bits, signed or unsigned per latched signed_mode, sign/zero-extended to AW; accumulation wraps modulo 2^AW.
REQ-026 SHALL transition FEED -> OUT after t = 3N-3, then present C row-major with out_valid=1; advance index only on out_valid&out_ready.
REQ-027 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-028 SHALL on the N*N-th output handshake go to IDLE and assert done for exactly that next cycle (first IDLE cycle); start in that cycle SHALL be accepted.
REQ-029 SHALL ignore start while busy=1.
REQ-030 SHALL support N=1 (FEED lasts 1 cycle).

Reset
REQ-031 SHALL on rst=1 (any state, mid-job included) go to IDLE next edge, clearing all counters, accumulators, operand buffers, latched modes.
REQ-032 SHALL reset outputs to in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-033 SHALL not emit done for a job aborted by reset.

Structure
REQ-034 SHALL place FSM state encoding, default N/DW and AW derivation function in shared package systolic_pkg.
REQ-035 SHALL instantiate N*N copies of one sub-module systolic_pe (MAC + forwarding registers, clear/enable/signed inputs).

Verification
REQ-036 N=4,DW=8 unsigned: A=identity, B[i][j]=4i+j -> outputs 0,1,...,15 in order, done once.
REQ-037 Signed: all A=-1 (0xFF), all B=2 -> all 16 outputs = -8 in AW bits.
REQ-038 acc_mode=1 second job after REQ-036 with same operands -> outputs 0,2,...,30.
REQ-039 out_ready toggled 1/0 each cycle and held low 5 cycles mid-stream -> no lost/duplicated element, out_data stable while stalled.
REQ-040 rst asserted during FEED, then fresh REQ-036 job -> correct results, no done for aborted job.
REQ-041 Unsigned all A=B=255 -> each output 260100 (4*65025), no overflow at default AW.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix-multiply engine.
package systolic_pkg;

    localparam int unsigned DEF_N  = 4;
    localparam int unsigned DEF_DW = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FEED = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // Accumulator width: full product plus enough headroom for N additions.
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned dw);
        return 2 * dw + $clog2(n) + 1;
    endfunction

    // Counter width for a range of 'count' values, never narrower than 1 bit.
    function automatic int unsigned idx_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// Processing element: MAC with right/down operand forwarding registers.
module systolic_pe #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic          signed_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] b_o,
    output logic [AW-1:0] acc_o
);

    localparam int unsigned PW = 2 * DW;

    logic        [DW-1:0] a_q, b_q;
    logic        [AW-1:0] acc_q, acc_d, prod_ext;
    logic signed [PW-1:0] a_s, b_s, p_s;
    logic        [PW-1:0] p_u;

    // Product in the latched number format, extended to accumulator width.
    always_comb begin
        a_s      = PW'($signed(a_i));
        b_s      = PW'($signed(b_i));
        p_s      = a_s * b_s;
        p_u      = PW'(a_i) * PW'(b_i);
        prod_ext = signed_i ? AW'(p_s) : AW'(p_u);
        acc_d    = (clr_i ? '0 : acc_q) + prod_ext;
    end

    // Accumulate while enabled; forwarding registers read zero between jobs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (en_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end else begin
            a_q   <= '0;
            b_q   <= '0;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic matrix multiplier with streaming load/unload.
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned AW = acc_width(N, DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          signed_mode,
    input  logic          acc_mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a_data,
    input  logic [DW-1:0] b_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic          busy,
    output logic          done
);

    localparam int unsigned NN = N * N;
    localparam int unsigned CW = idx_width(NN);
    localparam int unsigned TW = idx_width(3 * N - 2);

    state_t        state_q;
    logic [CW-1:0] ld_idx_q, out_idx_q;
    logic [TW-1:0] t_q;
    logic          signed_q, acc_mode_q, done_q;
    logic [DW-1:0] a_buf_q [NN];
    logic [DW-1:0] b_buf_q [NN];

    logic [DW-1:0] a_edge [N];
    logic [DW-1:0] b_edge [N];
    logic [DW-1:0] a_in_w  [N][N];
    logic [DW-1:0] b_in_w  [N][N];
    logic [DW-1:0] a_out_w [N][N];
    logic [DW-1:0] b_out_w [N][N];
    logic [AW-1:0] acc_w [NN];
    logic          feed_en, feed_clr, unused_fwd;
    int            tt;

    // Job sequencing, operand capture and all counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ld_idx_q   <= '0;
            out_idx_q  <= '0;
            t_q        <= '0;
            signed_q   <= 1'b0;
            acc_mode_q <= 1'b0;
            done_q     <= 1'b0;
            for (int k = 0; k < int'(NN); k++) begin
                a_buf_q[k] <= '0;
                b_buf_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        signed_q   <= signed_mode;
                        acc_mode_q <= acc_mode;
                        ld_idx_q   <= '0;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        a_buf_q[ld_idx_q] <= a_data;
                        b_buf_q[ld_idx_q] <= b_data;
                        if (ld_idx_q == CW'(NN - 1)) begin
                            ld_idx_q <= '0;
                            t_q      <= '0;
                            state_q  <= S_FEED;
                        end else begin
                            ld_idx_q <= ld_idx_q + CW'(1);
                        end
                    end
                end
                S_FEED: begin
                    if (t_q == TW'(3 * N - 3)) begin
                        t_q       <= '0;
                        out_idx_q <= '0;
                        state_q   <= S_OUT;
                    end else begin
                        t_q <= t_q + TW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (out_idx_q == CW'(NN - 1)) begin
                            out_idx_q <= '0;
                            done_q    <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            out_idx_q <= out_idx_q + CW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Skewed edge injection: row r gets A[r][t-r], column r gets B[t-r][r].
    always_comb begin
        tt = int'(t_q);
        for (int r = 0; r < int'(N); r++) begin
            a_edge[r] = '0;
            b_edge[r] = '0;
            if (state_q == S_FEED && tt >= r && (tt - r) < int'(N)) begin
                a_edge[r] = a_buf_q[CW'(r * int'(N) + tt - r)];
                b_edge[r] = b_buf_q[CW'(r * int'(N) + tt - r)];
            end
        end
    end

    assign feed_en  = (state_q == S_FEED);
    assign feed_clr = feed_en && (t_q == '0) && !acc_mode_q;

    // PE grid: operands enter at the left/top edges and ripple right/down.
    for (genvar i = 0; i < int'(N); i++) begin : g_row
        for (genvar j = 0; j < int'(N); j++) begin : g_col
            if (j == 0) begin : g_aedge
                assign a_in_w[i][j] = a_edge[i];
            end else begin : g_afwd
                assign a_in_w[i][j] = a_out_w[i][j-1];
            end
            if (i == 0) begin : g_bedge
                assign b_in_w[i][j] = b_edge[j];
            end else begin : g_bfwd
                assign b_in_w[i][j] = b_out_w[i-1][j];
            end
            systolic_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk      (clk),
                .rst      (rst),
                .en_i     (feed_en),
                .clr_i    (feed_clr),
                .signed_i (signed_q),
                .a_i      (a_in_w[i][j]),
                .b_i      (b_in_w[i][j]),
                .a_o      (a_out_w[i][j]),
                .b_o      (b_out_w[i][j]),
                .acc_o    (acc_w[i * N + j])
            );
        end
    end

    // Operands leaving the far edges of the array have no consumer.
    always_comb begin
        unused_fwd = 1'b0;
        for (int r = 0; r < int'(N); r++) begin
            unused_fwd = unused_fwd ^ (^a_out_w[r][N-1]) ^ (^b_out_w[N-1][r]);
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign out_data  = out_valid ? acc_w[out_idx_q] : '0;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed self-checking bench for systolic_mm_engine (N=4, DW=8).
module tb_systolic_mm_engine;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst, start, signed_mode, acc_mode, in_valid, out_ready;
    logic [DW-1:0] a_data, b_data;
    logic          in_ready, out_valid, busy, done;
    logic [AW-1:0] out_data;

    systolic_mm_engine #(.N(N), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .acc_mode    (acc_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_data      (a_data),
        .b_data      (b_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] A [N][N];
    logic [DW-1:0] B [N][N];
    logic [AW-1:0] c_prev [N*N];
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] got_q [$];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    int  out_cnt  = 0;
    int  cyc      = 0;
    int  stall_lo = 0;
    bit  rdy_mode = 1'b0;
    bit  prev_stall = 1'b0;
    bit  prev_done  = 1'b0;
    logic [AW-1:0] prev_data = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint opval(input logic [DW-1:0] x, input bit sgn);
        return sgn ? longint'($signed(x)) : longint'(x);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Sink back-pressure: always ready, or alternating with a 5-cycle stall window.
    always @(posedge clk) begin
        #1;
        if (!rdy_mode) out_ready = 1'b1;
        else out_ready = (cyc % 2 == 0) && !(cyc >= stall_lo && cyc < stall_lo + 5);
    end

    // Output scoreboard, stall stability and done pulse width.
    always @(negedge clk) begin
        if (prev_stall) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_data_held", out_data, prev_data);
        end
        if (prev_done) check("done_one_cycle", done, 0);
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %0d expected none", out_data);
            end else begin
                check($sformatf("out_elem_%0d", out_cnt), out_data, exp_q.pop_front());
                got_q.push_back(out_data);
            end
            out_cnt++;
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_data  = out_data;
        prev_done  = done;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
    endtask

    // Runs one job from the current negedge; abort=1 resets mid-FEED instead of unloading.
    task automatic run_job(input bit sgn, input bit accm, input bit abort);
        longint s;
        int     k;
        bit     gap, seen;
        got_q.delete();
        if (!abort) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    s = accm ? longint'(c_prev[i*N+j]) : 0;
                    for (int m = 0; m < N; m++) s += opval(A[i][m], sgn) * opval(B[m][j], sgn);
                    c_prev[i*N+j] = AW'(s);
                    exp_q.push_back(c_prev[i*N+j]);
                end
            end
        end
        start = 1'b1; signed_mode = sgn; acc_mode = accm;
        @(posedge clk); #1;
        start = 1'b0; signed_mode = !sgn; acc_mode = !accm;
        @(negedge clk);
        check("in_ready_after_start", in_ready, 1);
        check("busy_after_start", busy, 1);
        k = 0; gap = 1'b0;
        for (int c = 0; c < 200 && k < N*N; c++) begin
            if (in_ready) begin
                if (k == 5 && !gap) begin
                    in_valid = 1'b0; a_data = 8'hA5; b_data = 8'h5A; gap = 1'b1;
                end else begin
                    in_valid = 1'b1; a_data = A[k/N][k%N]; b_data = B[k%N][k/N]; k++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("load_pairs_accepted", k, N*N);
        check("in_ready_low_in_feed", in_ready, 0);
        if (abort) begin
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check_reset_outputs("abort_rst");
            @(negedge clk);
            rst = 1'b0;
            exp_q.delete();
            for (int i = 0; i < N*N; i++) c_prev[i] = '0;
        end else begin
            seen = 1'b0;
            for (int w = 0; w < 400 && !seen; w++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            check("done_seen", seen, 1);
            check("exp_drained", exp_q.size(), 0);
        end
    endtask

    task automatic set_identity_job();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = (i == j) ? 8'd1 : 8'd0;
                B[i][j] = DW'(4 * i + j);
            end
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; acc_mode = 1'b0;
        in_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b1;
        for (int i = 0; i < N*N; i++) c_prev[i] = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        // Identity times B returns B row-major.
        set_identity_job();
        run_job(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N*N; i++) check($sformatf("ident_lit_%0d", i), got_q[i], i);

        // Accumulating rerun under toggling/stalled sink, started in the done cycle.
        rdy_mode = 1'b1;
        stall_lo = cyc + 36;
        run_job(1'b0, 1'b1, 1'b0);
        rdy_mode = 1'b0;
        for (int i = 0; i < N*N; i++) check($sformatf("accum_lit_%0d", i), got_q[i], 2 * i);

        // Signed: (-1)*2 summed four times.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin A[i][j] = 8'hFF; B[i][j] = 8'd2; end
        run_job(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < N*N; i += 5) check($sformatf("signed_lit_%0d", i), got_q[i], 524280);

        // Unsigned extreme: 4 * 255 * 255.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin A[i][j] = 8'hFF; B[i][j] = 8'hFF; end
        run_job(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N*N; i += 3) check($sformatf("max_lit_%0d", i), got_q[i], 260100);

        // Abort during FEED, then a fresh accumulate-mode job sees cleared accumulators.
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        set_identity_job();
        run_job(1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("no_done_after_abort", done_cnt, d0);
        check("idle_after_abort", busy, 0);
        run_job(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < N*N; i++) check($sformatf("fresh_lit_%0d", i), got_q[i], i);

        repeat (3) @(negedge clk);
        check("done_total", done_cnt, 5);
        check("outputs_total", out_cnt, 5 * N * N);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
